// File: rtl/oled_pkg.sv
// Shared constants, state encoding and command-preamble helper for the SSD1331 frame streamer.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;

  // SSD1331 window-setup opcodes
  localparam logic [7:0] CMD_SET_COL = 8'h15;
  localparam logic [7:0] CMD_SET_ROW = 8'h75;

  // RGB565 colours used by the pattern generators
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] BLACK = 16'h0000;

  localparam int PREAMBLE_BYTES = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_PIX,
    ST_GAP
  } state_t;

  // Byte idx of the column/row window preamble: full-screen window 0..width-1, 0..height-1.
  function automatic logic [7:0] preamble_byte(input logic [2:0] idx,
                                               input int         width,
                                               input int         height);
    logic [7:0] b;
    case (idx)
      3'd0:    b = CMD_SET_COL;
      3'd1:    b = 8'h00;
      3'd2:    b = 8'(width - 1);
      3'd3:    b = CMD_SET_ROW;
      3'd4:    b = 8'h00;
      default: b = 8'(height - 1);
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// SPI mode-3 word serialiser: shifts an 8- or 16-bit word MSB first, 2*CLK_DIV cycles per bit.
// Latency: first bit (sclk low, sdin valid) on the cycle after load; word_done on the word's last cycle.
// Backpressure: none; load on the word_done cycle gives back-to-back words with no idle bits.
// Ports: clock, reset_n; load/wide/word (start a word, wide=16-bit else word[7:0]);
//        sclk, sdin (SPI pins); word_done (last cycle of the current word's final high half).
module spi_shifter
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        wide,
  input  logic [15:0] word,
  output logic        sclk,
  output logic        sdin,
  output logic        word_done
);

  localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  logic [15:0]   sreg;
  logic [3:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic          active;

  // The outgoing bit always sits at sreg[15]; bytes are loaded left-aligned.
  assign sdin      = sreg[15];
  assign word_done = active && sclk && (div_cnt == DIV_LAST) && (bit_cnt == 4'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sclk    <= 1'b1;
      active  <= 1'b0;
    end else if (load) begin
      sreg    <= wide ? word : {word[7:0], 8'h00};
      bit_cnt <= wide ? 4'd15 : 4'd7;
      div_cnt <= '0;
      sclk    <= 1'b0;
      active  <= 1'b1;
    end else if (active) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else if (bit_cnt == 4'd0) begin
          // Word finished with nothing queued: park with sclk high and sdin low.
          active <= 1'b0;
          sreg   <= '0;
        end else begin
          sreg    <= {sreg[14:0], 1'b0};
          bit_cnt <= bit_cnt - 4'd1;
          sclk    <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/oled_frame_streamer.sv
// Scans x/y over the panel, captures RGB565 from the generator and streams window preamble + frame over SPI.
// Latency: cs_n falls the cycle after enable is seen in IDLE; pixel captured at each word start, x/y advance next cycle.
// Backpressure: none; enable is only sampled in IDLE, a started frame always runs to completion.
// Ports: clock, reset_n, enable, pixel_data (in); x, y, frame_begin, frame_done, busy, cs_n, sclk, sdin, d_cn (out).
module oled_frame_streamer
  import oled_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4,
  parameter int WIDTH      = OLED_WIDTH,
  parameter int HEIGHT     = OLED_HEIGHT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] pixel_data,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic        frame_begin,
  output logic        frame_done,
  output logic        busy,
  output logic        cs_n,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn
);

  localparam logic [13:0]    PIX_LAST = 14'(WIDTH * HEIGHT - 1);
  localparam logic [6:0]     X_LAST   = 7'(WIDTH - 1);
  localparam logic [5:0]     Y_LAST   = 6'(HEIGHT - 1);
  localparam logic [2:0]     BYTE_LAST = 3'(PREAMBLE_BYTES - 1);
  localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t        state_q, state_d;
  logic [2:0]    byte_idx;
  logic [13:0]   pix_idx;
  logic [GW-1:0] gap_cnt;

  logic          sh_load, sh_wide, word_done;
  logic [15:0]   sh_word;
  logic          capture;
  logic          begin_d, done_d;
  logic          frame_begin_q, frame_done_q, d_cn_q;

  spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (sh_load),
    .wide      (sh_wide),
    .word      (sh_word),
    .sclk      (sclk),
    .sdin      (sdin),
    .word_done (word_done)
  );

  // Next word is loaded on the final cycle of the current one, so bits run back-to-back
  // from the first preamble bit to the last pixel bit.
  always_comb begin
    state_d = state_q;
    sh_load = 1'b0;
    sh_wide = 1'b0;
    sh_word = '0;
    begin_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_CMD;
          sh_load = 1'b1;
          sh_word = {8'h00, preamble_byte(3'd0, WIDTH, HEIGHT)};
          begin_d = 1'b1;
        end
      end
      ST_CMD: begin
        if (word_done) begin
          sh_load = 1'b1;
          if (byte_idx == BYTE_LAST) begin
            state_d = ST_PIX;
            sh_wide = 1'b1;
            sh_word = pixel_data;
          end else begin
            sh_word = {8'h00, preamble_byte(byte_idx + 3'd1, WIDTH, HEIGHT)};
          end
        end
      end
      ST_PIX: begin
        if (word_done) begin
          if (pix_idx == PIX_LAST) begin
            state_d = ST_GAP;
            done_d  = 1'b1;
          end else begin
            sh_load = 1'b1;
            sh_wide = 1'b1;
            sh_word = pixel_data;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign capture = sh_load && sh_wide;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      byte_idx      <= '0;
      pix_idx       <= '0;
      gap_cnt       <= '0;
      x             <= '0;
      y             <= '0;
      frame_begin_q <= 1'b0;
      frame_done_q  <= 1'b0;
      d_cn_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_begin_q <= begin_d;
      frame_done_q  <= done_d;

      if (state_q == ST_IDLE) begin
        byte_idx <= '0;
      end else if ((state_q == ST_CMD) && word_done) begin
        byte_idx <= byte_idx + 3'd1;
      end

      // pix_idx names the word currently in the shifter
      if (capture) begin
        pix_idx <= (state_q == ST_CMD) ? 14'd0 : pix_idx + 14'd1;
      end

      gap_cnt <= (state_q == ST_GAP) ? gap_cnt + GW'(1) : '0;

      // x/y point at the next pixel to capture; after the last one they wrap to (0,0),
      // which is also what the next frame's first capture needs.
      if (capture) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? 6'd0 : y + 6'd1;
        end else begin
          x <= x + 7'd1;
        end
      end

      // d_cn switches only at word boundaries, i.e. right after an sclk high half.
      if (capture && (state_q == ST_CMD)) begin
        d_cn_q <= 1'b1;
      end else if (done_d) begin
        d_cn_q <= 1'b0;
      end
    end
  end

  assign cs_n        = !((state_q == ST_CMD) || (state_q == ST_PIX));
  assign busy        = (state_q != ST_IDLE);
  assign frame_begin = frame_begin_q;
  assign frame_done  = frame_done_q;
  assign d_cn        = d_cn_q;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Self-checking bench: table of early-frame cycle expectations, reset corner cases, and randomized
// frames decoded off the SPI pins and compared against a frame model (preamble + row-major image).
// Ports: none (top-level bench).
module tb_oled_frame_streamer;
  import oled_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int GAP     = 4;
  localparam int W       = 8;
  localparam int H       = 4;
  localparam int N       = W * H;
  localparam int NBITS   = 48 + 16 * N;
  localparam int LOW_CYC = NBITS * 2 * CLK_DIV;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] pixel_data = 16'h0000;
  logic [6:0]  x;
  logic [5:0]  y;
  logic        frame_begin, frame_done, busy, cs_n, sclk, sdin, d_cn;

  always #5 clock = ~clock;

  oled_frame_streamer #(
    .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP), .WIDTH(W), .HEIGHT(H)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .pixel_data(pixel_data),
    .x(x), .y(y), .frame_begin(frame_begin), .frame_done(frame_done), .busy(busy),
    .cs_n(cs_n), .sclk(sclk), .sdin(sdin), .d_cn(d_cn)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] img[N];
  logic [7:0]  pre[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Registered pattern generator: pixel_data follows x/y one cycle later.
  initial begin : gen
    int pend;
    pend = 0;
    forever begin
      @(negedge clock);
      pixel_data = img[pend];
      pend = int'(y) * W + int'(x);
      if (pend >= N || pend < 0) pend = 0;
    end
  end

  // ---------------- SPI / frame monitor ----------------
  logic [1:0] bitq[$];
  int   low_cnt, gap_cnt, xy_chg, frames_done;
  logic prev_sclk, prev_cs, prev_dcn;
  logic [6:0] px;
  logic [5:0] py;
  bit   have_done, en_ok;

  initial frames_done = 0;

  always @(negedge clock) begin : mon
    int k, nx, ny;
    logic [7:0]  b;
    logic [15:0] w;
    logic        dc_any, dc_all;
    if (!reset_n) begin
      bitq.delete();
      low_cnt = 0; xy_chg = 0; gap_cnt = 0;
      prev_sclk = 1'b1; prev_cs = 1'b1; prev_dcn = 1'b0;
      px = '0; py = '0; have_done = 0; en_ok = 0;
    end else begin
      if (!cs_n && !prev_sclk && sclk) bitq.push_back({d_cn, sdin});
      if (!cs_n) low_cnt++;
      if (d_cn !== prev_dcn) check("dcn_change_after_sclk_high", prev_sclk, 1);
      if (x !== px || y !== py) begin
        k  = (int'(py) * W + int'(px) + 1) % N;
        nx = k % W;
        ny = k / W;
        check("xy_step", {x, y}, {7'(nx), 6'(ny)});
        xy_chg++;
        px = x; py = y;
      end
      if (frame_begin) begin
        check("begin_edge", {prev_cs, cs_n, busy, sclk}, 4'b1010);
        check("begin_xy", {x, y}, 0);
        if (have_done && en_ok) check("gap_len", gap_cnt, GAP + 1);
        bitq.delete();
        low_cnt = 1; xy_chg = 0; have_done = 0;
      end else if (have_done) begin
        if (cs_n) gap_cnt++;
        en_ok = en_ok && enable;
        check("gap_busy", busy, (gap_cnt <= GAP) ? 1 : 0);
      end
      if (frame_done) begin
        check("done_edge", {prev_cs, cs_n, sclk, busy}, 4'b0111);
        check("cs_low_cycles", low_cnt, LOW_CYC);
        check("xy_captures", xy_chg, N);
        check("bit_count", bitq.size(), NBITS);
        if (bitq.size() == NBITS) begin
          for (int i = 0; i < 6; i++) begin
            b = '0; dc_any = 1'b0;
            for (int j = 0; j < 8; j++) begin
              b = {b[6:0], bitq[i*8+j][0]};
              dc_any = dc_any | bitq[i*8+j][1];
            end
            check("preamble_byte", {dc_any, b}, {1'b0, pre[i]});
          end
          for (int kk = 0; kk < N; kk++) begin
            w = '0; dc_all = 1'b1;
            for (int j = 0; j < 16; j++) begin
              w = {w[14:0], bitq[48+kk*16+j][0]};
              dc_all = dc_all & bitq[48+kk*16+j][1];
            end
            check("pixel_word", {dc_all, w}, {1'b1, img[kk]});
          end
        end
        frames_done++;
        have_done = 1; gap_cnt = 1; en_ok = enable;
      end
      prev_sclk = sclk; prev_cs = cs_n; prev_dcn = d_cn;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int         cyc;   // negedge samples after reset release (0 = before any active edge)
    logic       en;    // enable applied
    logic [5:0] exp;   // {cs_n, sclk, sdin, d_cn, busy, frame_begin}
  } vec_t;
  vec_t tbl[12];

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_frames(input int target, input int limit);
    for (int i = 0; i < limit && frames_done < target; i++) @(negedge clock);
    check("frame_done_reached", (frames_done >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_pix(input int limit);
    int i;
    i = 0;
    while (i < limit && !(d_cn === 1'b1 && x >= 7'd3)) begin
      @(negedge clock);
      i++;
    end
    check("reached_pix", (d_cn === 1'b1 && x >= 7'd3) ? 1 : 0, 1);
  endtask

  initial begin : main
    logic bad;
    pre[0] = 8'h15; pre[1] = 8'h00; pre[2] = 8'(W - 1);
    pre[3] = 8'h75; pre[4] = 8'h00; pre[5] = 8'(H - 1);
    for (int k = 0; k < N; k++) img[k] = ((k % W) < W / 2) ? RED : BLACK;

    // bit i of the frame occupies samples 1+4i..4+4i (sclk low, low, high, high)
    tbl[0]  = '{0,  1'b1, 6'b110000};
    tbl[1]  = '{1,  1'b1, 6'b000011};
    tbl[2]  = '{2,  1'b1, 6'b000010};
    tbl[3]  = '{3,  1'b1, 6'b010010};
    tbl[4]  = '{13, 1'b1, 6'b001010};
    tbl[5]  = '{16, 1'b1, 6'b011010};
    tbl[6]  = '{17, 1'b1, 6'b000010};
    tbl[7]  = '{21, 1'b1, 6'b001010};
    tbl[8]  = '{32, 1'b1, 6'b011010};
    tbl[9]  = '{33, 1'b1, 6'b000010};
    tbl[10] = '{84, 1'b1, 6'b010010};
    tbl[11] = '{85, 1'b1, 6'b001010};

    // Reset held with enable high
    enable  = 1'b1;
    reset_n = 1'b0;
    repeat (3) step();
    check("reset_pins", {cs_n, sclk, sdin, d_cn, busy, frame_begin, frame_done}, 7'b1100000);
    check("reset_xy", {x, y}, 0);

    step();
    reset_n = 1'b1;
    for (int c = 0; c <= 85; c++) begin
      @(negedge clock);
      for (int r = 0; r < 12; r++) begin
        if (tbl[r].cyc == c) begin
          enable = tbl[r].en;
          check($sformatf("tbl_cycle_%0d", c), {cs_n, sclk, sdin, d_cn, busy, frame_begin}, tbl[r].exp);
        end
      end
    end

    // Asynchronous reset in the middle of the pixel phase
    wait_pix(3000);
    step();
    reset_n = 1'b0;
    #1;
    check("midframe_reset_pins", {cs_n, sclk, busy, frame_begin, frame_done, d_cn}, 6'b110000);
    check("midframe_reset_xy", {x, y}, 0);
    repeat (2) step();

    // Back-to-back frames: first with half-red rows, then random images
    enable  = 1'b1;
    reset_n = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      wait_frames(f, LOW_CYC + 200);
      for (int k = 0; k < N; k++) img[k] = 16'($urandom);
    end

    // Drop enable at a random point inside the pixel phase of frame 4
    wait_pix(LOW_CYC);
    repeat ($urandom_range(0, 1500)) step();
    step();
    enable = 1'b0;
    wait_frames(4, LOW_CYC + 200);

    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (frame_begin !== 1'b0 || cs_n !== 1'b1 || (i > GAP + 2 && busy !== 1'b0)) bad = 1'b1;
    end
    check("no_restart_after_enable_drop", bad, 0);
    check("frame_total", frames_done, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #600000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, frames_done=%0d", frames_done);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
